// File: rtl/ec_fpn_sub_mod_if.sv
// ec_fpn_sub_mod_if: stream beat bundle (data, tag, framing, handshake) used on both sides of the subtractor
interface ec_fpn_sub_mod_if #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8
);
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic sop, eop, err, val, rdy;
    modport master (output dat, ctl, sop, eop, err, val, input rdy);
    modport slave (input dat, ctl, sop, eop, val, output rdy);
endinterface

// File: rtl/ec_fpn_sub_mod.sv
// ec_fpn_sub_mod: word-serial a - b mod P; borrow chain on load, conditional add-back of P on emit
module ec_fpn_sub_mod #(
    parameter int FE_BITS = 384,
    parameter int ARITH_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter logic [FE_BITS-1:0] P = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
) (
    input logic i_clk,
    input logic i_rst_n,
    ec_fpn_sub_mod_if.slave i_sub_if,
    ec_fpn_sub_mod_if.master o_sub_if
);
    localparam int AB = ARITH_BITS;
    localparam int DIV = FE_BITS / ARITH_BITS;
    localparam int KW = $clog2(DIV);
    typedef enum logic {LOAD, EMIT} state_t;
    state_t state;
    logic [AB-1:0] d [DIV];
    logic [AB-1:0] d_nx [DIV];
    logic [KW-1:0] k, kk, j, jn;
    logic [CTL_BITS-1:0] ctl_l;
    logic bw, corr, c, err_pend, restart, done, acc;
    logic [AB:0] diff, sum0, sum_n;
    always_comb begin
        acc = i_sub_if.val && i_sub_if.rdy;
        restart = i_sub_if.sop && k != '0;
        kk = restart ? '0 : k;
        diff = {1'b0, i_sub_if.dat[0+:AB]} - {1'b0, i_sub_if.dat[AB+:AB]} - {{AB{1'b0}}, bw && kk != '0};
        done = i_sub_if.eop || kk == KW'(DIV-1);
        // an early eop leaves the upper words as 0 - 0 - borrow, i.e. all-ones while the borrow persists
        for (int m = 0; m < DIV; m++)
            d_nx[m] = (KW'(m) == kk) ? diff[AB-1:0] : (done && KW'(m) > kk) ? {AB{diff[AB]}} : d[m];
        sum0 = {1'b0, d_nx[0]} + {1'b0, diff[AB] ? P[AB-1:0] : {AB{1'b0}}};
        jn = j + 1'b1;
        sum_n = {1'b0, d[jn]} + {1'b0, corr ? P[jn*AB +: AB] : {AB{1'b0}}} + {{AB{1'b0}}, c};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= LOAD;
            for (int m = 0; m < DIV; m++) d[m] <= '0;
            k <= '0;
            j <= '0;
            ctl_l <= '0;
            bw <= 1'b0;
            corr <= 1'b0;
            c <= 1'b0;
            err_pend <= 1'b0;
            i_sub_if.rdy <= 1'b0;
            o_sub_if.val <= 1'b0;
            o_sub_if.sop <= 1'b0;
            o_sub_if.eop <= 1'b0;
            o_sub_if.err <= 1'b0;
            o_sub_if.dat <= '0;
            o_sub_if.ctl <= '0;
        end else if (state == LOAD) begin
            i_sub_if.rdy <= !(acc && done);
            if (acc) begin
                for (int m = 0; m < DIV; m++) d[m] <= d_nx[m];
                if (kk == '0) ctl_l <= i_sub_if.ctl;
                if (restart || (done && (i_sub_if.eop != (kk == KW'(DIV-1))))) err_pend <= 1'b1;
                if (done) begin
                    state <= EMIT;
                    corr <= diff[AB];
                    k <= '0;
                    bw <= 1'b0;
                    j <= '0;
                    c <= sum0[AB];
                    o_sub_if.dat <= sum0[AB-1:0];
                    o_sub_if.ctl <= (kk == '0) ? i_sub_if.ctl : ctl_l;
                    o_sub_if.val <= 1'b1;
                    o_sub_if.sop <= 1'b1;
                    o_sub_if.eop <= 1'b0;
                    o_sub_if.err <= 1'b0;
                end else begin
                    k <= kk + 1'b1;
                    bw <= diff[AB];
                end
            end
        end else if (o_sub_if.rdy) begin
            if (j == KW'(DIV-1)) begin
                state <= LOAD;
                i_sub_if.rdy <= 1'b1;
                err_pend <= 1'b0;
                j <= '0;
                c <= 1'b0;
                o_sub_if.val <= 1'b0;
                o_sub_if.sop <= 1'b0;
                o_sub_if.eop <= 1'b0;
                o_sub_if.err <= 1'b0;
            end else begin
                j <= jn;
                c <= sum_n[AB];
                o_sub_if.dat <= sum_n[AB-1:0];
                o_sub_if.sop <= 1'b0;
                o_sub_if.eop <= jn == KW'(DIV-1);
                o_sub_if.err <= (jn == KW'(DIV-1)) && err_pend;
            end
        end
    end
endmodule

// File: tb/tb_ec_fpn_sub_mod.sv
// tb_ec_fpn_sub_mod: directed checks of the serial modular subtractor with a 384-bit reference
module tb_ec_fpn_sub_mod;
    localparam int AB = 64;
    localparam int DIV = 6;
    localparam int CB = 8;
    localparam logic [383:0] P = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    ec_fpn_sub_mod_if #(.DAT_BITS(2*AB), .CTL_BITS(CB)) in_if();
    ec_fpn_sub_mod_if #(.DAT_BITS(AB), .CTL_BITS(CB)) out_if();
    ec_fpn_sub_mod #(.FE_BITS(384), .ARITH_BITS(AB), .CTL_BITS(CB)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_sub_if(in_if),
        .o_sub_if(out_if)
    );
    always #5 i_clk = ~i_clk;

    function automatic logic [383:0] model(input logic [383:0] a, input logic [383:0] b);
        logic [384:0] t;
        t = {1'b0, a} - {1'b0, b};
        return t[384] ? t[383:0] + P : t[383:0];
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [383:0] a, input logic [383:0] b, input logic [7:0] ctl, input int n, input bit eop_last);
        for (int k = 0; k < n; k++) begin
            int t;
            in_if.val = 1'b1;
            in_if.dat = {b[k*AB +: AB], a[k*AB +: AB]};
            in_if.ctl = ctl;
            in_if.sop = (k == 0);
            in_if.eop = eop_last && (k == n-1);
            t = 0;
            while (!in_if.rdy && t < 40) begin
                tick();
                t++;
            end
            chk("in_rdy", {383'd0, in_if.rdy}, 384'd1);
            tick();
        end
        in_if.val = 1'b0;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
        if (eop_last) begin
            chk("latency_val", {383'd0, out_if.val}, 384'd1);
            chk("in_rdy_low", {383'd0, in_if.rdy}, 384'd0);
        end
    endtask

    task automatic recv(input logic [383:0] exp, input logic [7:0] ctl, input bit err_exp, input bit stall);
        for (int j = 0; j < DIV; j++) begin
            int s;
            s = stall ? ((j == 2) ? 3 : int'($urandom_range(0, 1))) : 0;
            out_if.rdy = 1'b0;
            for (int i = 0; i < s; i++) begin
                chk("hold_dat", {320'd0, out_if.dat}, {320'd0, exp[j*AB +: AB]});
                chk("hold_rdy_in", {383'd0, in_if.rdy}, 384'd0);
                tick();
            end
            chk("val", {383'd0, out_if.val}, 384'd1);
            chk("dat", {320'd0, out_if.dat}, {320'd0, exp[j*AB +: AB]});
            chk("sop", {383'd0, out_if.sop}, {383'd0, j == 0});
            chk("eop", {383'd0, out_if.eop}, {383'd0, j == DIV-1});
            chk("ctl", {376'd0, out_if.ctl}, {376'd0, ctl});
            chk("err", {383'd0, out_if.err}, {383'd0, err_exp && j == DIV-1});
            chk("emit_rdy_in", {383'd0, in_if.rdy}, 384'd0);
            out_if.rdy = 1'b1;
            tick();
        end
        out_if.rdy = 1'b0;
        chk("val_drop", {383'd0, out_if.val}, 384'd0);
        chk("rdy_back", {383'd0, in_if.rdy}, 384'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [383:0] x, y;
        in_if.val = 1'b0;
        in_if.dat = '0;
        in_if.ctl = '0;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
        in_if.err = 1'b0;
        out_if.rdy = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_val", {383'd0, out_if.val}, 384'd0);
        chk("rst_sop", {383'd0, out_if.sop}, 384'd0);
        chk("rst_eop", {383'd0, out_if.eop}, 384'd0);
        chk("rst_err", {383'd0, out_if.err}, 384'd0);
        chk("rst_dat", {320'd0, out_if.dat}, 384'd0);
        chk("rst_ctl", {376'd0, out_if.ctl}, 384'd0);
        chk("rst_rdy", {383'd0, in_if.rdy}, 384'd0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        send(384'd5, 384'd3, 8'd8, 6, 1'b1);
        recv(384'd2, 8'd8, 1'b0, 1'b0);
        send(384'd3, 384'd5, 8'd1, 6, 1'b1);
        recv(384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaa9, 8'd1, 1'b0, 1'b0);
        send(P - 384'd1, P - 384'd1, 8'd2, 6, 1'b1);
        recv(384'd0, 8'd2, 1'b0, 1'b0);
        send(384'd0, P - 384'd1, 8'd3, 6, 1'b1);
        recv(384'd1, 8'd3, 1'b0, 1'b0);
        send(P - 384'd1, 384'd0, 8'd4, 6, 1'b1);
        recv(P - 384'd1, 8'd4, 1'b0, 1'b0);
        x = 384'h0123456789abcdef_fedcba9876543210_0f0f0f0f0f0f0f0f_ffffffffffffffff_0000000000000001_8000000000000000;
        y = 384'h0fedcba987654321_0123456789abcdef_f0f0f0f0f0f0f0f0_0000000000000001_ffffffffffffffff_7fffffffffffffff;
        send(x, y, 8'h15, 6, 1'b1);
        recv(model(x, y), 8'h15, 1'b0, 1'b1);
        send(y, x, 8'h16, 6, 1'b1);
        recv(model(y, x), 8'h16, 1'b0, 1'b1);
        send(P - 384'd1, 384'd1, 8'h17, 6, 1'b1);
        recv(P - 384'd2, 8'h17, 1'b0, 1'b1);
        send(384'd7, 384'd9, 8'h21, 4, 1'b1);
        recv(P - 384'd2, 8'h21, 1'b1, 1'b0);
        send(384'd11, 384'd2, 8'h30, 3, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_val", {383'd0, out_if.val}, 384'd0);
        chk("mid_rst_err", {383'd0, out_if.err}, 384'd0);
        chk("mid_rst_dat", {320'd0, out_if.dat}, 384'd0);
        chk("mid_rst_ctl", {376'd0, out_if.ctl}, 384'd0);
        chk("mid_rst_rdy", {383'd0, in_if.rdy}, 384'd0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_val", {383'd0, out_if.val}, 384'd0);
        send(384'd10, 384'd4, 8'h31, 6, 1'b1);
        recv(384'd6, 8'h31, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
